// File: rtl/fc_layer_sequencer_pkg.sv
// Shared types and widths for the fully-connected layer sequencer.
package fc_seq_pkg;

    localparam int LANES  = 4;
    localparam int ACC_W  = 32;
    localparam int LANE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_REQ,
        S_WAIT,
        S_ACC,
        S_EMIT,
        S_FIN
    } fc_seq_state_t;

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Chunk-read request/response port and final-sum stream of the layer sequencer.
interface fc_layer_sequencer_if
    import fc_seq_pkg::*;
#(
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 16
);
    logic                      rd_valid;
    logic                      rd_ready;
    logic [ADDR_W-1:0]         rd_act_addr;
    logic [ADDR_W-1:0]         rd_wt_addr;
    logic                      rsp_valid;
    logic [LANES*LANE_W-1:0]   rsp_act;
    logic [LANES*LANE_W-1:0]   rsp_wt;
    logic                      res_valid;
    logic                      res_ready;
    logic [ACC_W-1:0]          res_sum;
    logic [OUT_W-1:0]          res_idx;

    modport master (
        output rd_valid, rd_act_addr, rd_wt_addr,
        input  rd_ready,
        input  rsp_valid, rsp_act, rsp_wt,
        output res_valid, res_sum, res_idx,
        input  res_ready
    );

    modport slave (
        input  rd_valid, rd_act_addr, rd_wt_addr,
        output rd_ready,
        output rsp_valid, rsp_act, rsp_wt,
        input  res_valid, res_sum, res_idx,
        output res_ready
    );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Multi-chunk FC layer sequencer feeding a 4-lane INT8 MAC array; optional
// perf counters under FC_SEQ_PERF_CNT_EN.
// state | meaning
// IDLE  | wait for start | BIAS | load neuron bias | REQ | chunk read request
// WAIT  | await response | ACC  | fold chunk into acc | EMIT | offer sum | FIN | done pulse
module fc_layer_sequencer
    import fc_seq_pkg::*;
#(
    parameter int CHUNK_W = 8,
    parameter int OUT_W   = 8,
    parameter int ADDR_W  = 16
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CHUNK_W-1:0]       cfg_num_chunks,
    input  logic [OUT_W-1:0]         cfg_num_out,
    output logic                     busy,
    output logic                     done,
    output logic [OUT_W-1:0]         bias_idx,
    input  logic [ACC_W-1:0]         bias_in,
    fc_layer_sequencer_if.master     bus,
    output logic [LANES*LANE_W-1:0]  mac_act,
    output logic [LANES*LANE_W-1:0]  mac_wt,
    output logic [ACC_W-1:0]         mac_bias,
    input  logic [ACC_W-1:0]         mac_sum
`ifdef FC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]              perf_cycles,
    output logic [15:0]              perf_zero_chunks
`endif
);

    fc_seq_state_t             state;
    logic [CHUNK_W-1:0]        num_chunks;
    logic [OUT_W-1:0]          num_out;
    logic [CHUNK_W-1:0]        k;
    logic [OUT_W-1:0]          o;
    logic [ADDR_W-1:0]         wt_addr;
    logic [ACC_W-1:0]          acc;
    logic [LANES*LANE_W-1:0]   lane_act;
    logic [LANES*LANE_W-1:0]   lane_wt;
    logic                      rd_valid_q;
    logic                      res_valid_q;

    assign bias_idx        = o;
    assign mac_act         = lane_act;
    assign mac_wt          = lane_wt;
    assign mac_bias        = acc;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_act_addr = ADDR_W'(k);
    assign bus.rd_wt_addr  = wt_addr;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_sum     = acc;
    assign bus.res_idx     = o;

    // wt_addr walks o*num_chunks + k by stepping once per accumulated chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            num_chunks  <= '0;
            num_out     <= '0;
            k           <= '0;
            o           <= '0;
            wt_addr     <= '0;
            acc         <= '0;
            lane_act    <= '0;
            lane_wt     <= '0;
            rd_valid_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        num_chunks <= cfg_num_chunks;
                        num_out    <= cfg_num_out;
                        o          <= '0;
                        k          <= '0;
                        wt_addr    <= '0;
                        busy       <= 1'b1;
                        if (cfg_num_chunks == '0 || cfg_num_out == '0) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            state <= S_BIAS;
                        end
                    end
                end
                S_BIAS: begin
                    acc        <= bias_in;
                    k          <= '0;
                    rd_valid_q <= 1'b1;
                    state      <= S_REQ;
                end
                S_REQ: begin
                    if (bus.rd_ready) begin
                        rd_valid_q <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.rsp_valid) begin
                        lane_act <= bus.rsp_act;
                        lane_wt  <= bus.rsp_wt;
                        state    <= S_ACC;
                    end
                end
                S_ACC: begin
                    acc     <= mac_sum;
                    wt_addr <= wt_addr + ADDR_W'(1);
                    if (k == num_chunks - CHUNK_W'(1)) begin
                        res_valid_q <= 1'b1;
                        state       <= S_EMIT;
                    end else begin
                        k          <= k + CHUNK_W'(1);
                        rd_valid_q <= 1'b1;
                        state      <= S_REQ;
                    end
                end
                S_EMIT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (o == num_out - OUT_W'(1)) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            o     <= o + OUT_W'(1);
                            state <= S_BIAS;
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FC_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles      <= '0;
            perf_zero_chunks <= '0;
        end else if (state == S_IDLE && start) begin
            perf_cycles      <= '0;
            perf_zero_chunks <= '0;
        end else begin
            if (busy && perf_cycles != '1)
                perf_cycles <= perf_cycles + 32'd1;
            if (state == S_ACC && lane_act == '0 && perf_zero_chunks != '1)
                perf_zero_chunks <= perf_zero_chunks + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer with a behavioural memory, MAC array model and result sink.
`timescale 1ns/1ps
module tb_fc_layer_sequencer;
    import fc_seq_pkg::*;

    localparam int CHUNK_W = 8;
    localparam int OUT_W   = 8;
    localparam int ADDR_W  = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [CHUNK_W-1:0] cfg_num_chunks;
    logic [OUT_W-1:0]   cfg_num_out;
    logic               busy;
    logic               done;
    logic [OUT_W-1:0]   bias_idx;
    logic [31:0]        bias_in;
    logic [31:0]        mac_act;
    logic [31:0]        mac_wt;
    logic [31:0]        mac_bias;
    logic [31:0]        mac_sum;
`ifdef FC_SEQ_PERF_CNT_EN
    logic [31:0]        perf_cycles;
    logic [15:0]        perf_zero_chunks;
`endif

    fc_layer_sequencer_if #(.OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

    fc_layer_sequencer #(.CHUNK_W(CHUNK_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_num_chunks (cfg_num_chunks),
        .cfg_num_out    (cfg_num_out),
        .busy           (busy),
        .done           (done),
        .bias_idx       (bias_idx),
        .bias_in        (bias_in),
        .bus            (bus),
        .mac_act        (mac_act),
        .mac_wt         (mac_wt),
        .mac_bias       (mac_bias),
        .mac_sum        (mac_sum)
`ifdef FC_SEQ_PERF_CNT_EN
        ,
        .perf_cycles      (perf_cycles),
        .perf_zero_chunks (perf_zero_chunks)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] act_mem  [16];
    logic [31:0] wt_mem   [16];
    logic [31:0] bias_mem [16];

    assign bias_in = bias_mem[bias_idx[3:0]];

    // MAC array model: bias plus four sign-extended INT8 products, wrapping at 32 bits.
    always_comb begin
        int p;
        mac_sum = mac_bias;
        for (int i = 0; i < 4; i++) begin
            p = int'($signed(mac_act[8*i +: 8])) * int'($signed(mac_wt[8*i +: 8]));
            mac_sum = mac_sum + 32'(p);
        end
    end

    // Memory responder: optional rd_ready stall, response a fixed number of cycles after acceptance.
    int          rdy_stall = 0;
    int          rsp_delay = 1;
    int          stall_cnt = 0;
    int          rsp_cnt   = 0;
    bit          accepted  = 0;
    bit          in_req    = 0;
    bit          saw_rsp   = 0;
    logic [15:0] lat_a, lat_w, first_a, first_w;
    logic [15:0] act_q [$];
    logic [15:0] wt_q  [$];

    initial begin
        bus.rd_ready  = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_act   = '0;
        bus.rsp_wt    = '0;
        forever begin
            @(negedge clk);
            bus.rsp_valid = 1'b0;
            if (accepted) begin
                accepted = 0;
                rsp_cnt  = rsp_delay;
            end
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_act   = act_mem[lat_a[3:0]];
                    bus.rsp_wt    = wt_mem[lat_w[3:0]];
                    saw_rsp       = 1;
                end
            end
            bus.rd_ready = 1'b0;
            if (bus.rd_valid === 1'b1) begin
                if (!in_req) begin
                    in_req    = 1;
                    first_a   = bus.rd_act_addr;
                    first_w   = bus.rd_wt_addr;
                    stall_cnt = 0;
                end else begin
                    total++;
                    if (bus.rd_act_addr !== first_a || bus.rd_wt_addr !== first_w) begin
                        bad++;
                        $display("FAIL req_stable: act_addr=%0d wt_addr=%0d required %0d %0d",
                                 bus.rd_act_addr, bus.rd_wt_addr, first_a, first_w);
                    end
                end
                if (stall_cnt < rdy_stall) begin
                    stall_cnt++;
                end else begin
                    bus.rd_ready = 1'b1;
                    accepted     = 1;
                    in_req       = 0;
                    lat_a        = bus.rd_act_addr;
                    lat_w        = bus.rd_wt_addr;
                    act_q.push_back(bus.rd_act_addr);
                    wt_q.push_back(bus.rd_wt_addr);
                end
            end else begin
                in_req = 0;
            end
        end
    end

    task automatic launch(input logic [CHUNK_W-1:0] c, input logic [OUT_W-1:0] n);
        @(negedge clk);
        cfg_num_chunks = c;
        cfg_num_out    = n;
        start          = 1'b1;
    endtask

    task automatic load_basic();
        act_mem[0]  = 32'h0403_0201;
        wt_mem[0]   = 32'h0101_0101;
        wt_mem[1]   = 32'h0202_0202;
        bias_mem[0] = 32'd10;
        bias_mem[1] = 32'd100;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        cfg_num_chunks = '0;
        cfg_num_out = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            act_mem[i] = '0; wt_mem[i] = '0; bias_mem[i] = '0;
        end
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, bus.rd_valid, bus.res_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: busy/done/rd_valid/res_valid=%b required 0000",
                     {busy, done, bus.rd_valid, bus.res_valid});
        end
        total++;
        if (mac_act !== '0 || mac_wt !== '0 || mac_bias !== '0 || bus.res_sum !== '0 ||
            bias_idx !== '0 || bus.res_idx !== '0 || bus.rd_wt_addr !== '0) begin
            bad++;
            $display("FAIL reset_data: act=%h wt=%h bias=%h sum=%h required all 0",
                     mac_act, mac_wt, mac_bias, bus.res_sum);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int res_cyc = -1, done_cyc = -1;
        logic [31:0] sum;
        logic [OUT_W-1:0] idx;
        load_basic();
        bus.res_ready = 1'b1;
        launch(8'd1, 8'd1);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: busy=%b required 1", busy); end
            end
            if (bus.res_valid === 1'b1 && res_cyc < 0) begin
                res_cyc = cyc; sum = bus.res_sum; idx = bus.res_idx;
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (cyc == 8) begin
                total++;
                if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy=%b required 0", busy); end
            end
        end
        total++;
        if (res_cyc != 5) begin bad++; $display("FAIL single_res_cycle: got %0d required 5", res_cyc); end
        total++;
        if (sum !== 32'd20 || idx !== '0) begin
            bad++; $display("FAIL single_sum: sum=%0d idx=%0d required 20 0", $signed(sum), idx);
        end
        total++;
        if (done_cyc != 6) begin bad++; $display("FAIL single_done_cycle: got %0d required 6", done_cyc); end
    endtask

    task automatic test_two_by_two();
        logic [31:0] sums [2];
        logic [OUT_W-1:0] idxs [2];
        int nres = 0, done_cyc = -1;
        act_mem[0]  = 32'h0101_0101;
        act_mem[1]  = 32'hFFFF_FFFF;
        wt_mem[0]   = 32'h0202_0202;
        wt_mem[1]   = 32'h0303_0303;
        wt_mem[2]   = 32'hFFFF_FFFF;
        wt_mem[3]   = 32'h0101_0101;
        bias_mem[0] = 32'd0;
        bias_mem[1] = 32'd100;
        act_q.delete();
        wt_q.delete();
        bus.res_ready = 1'b1;
        launch(8'd2, 8'd2);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.res_valid === 1'b1 && nres < 2) begin
                sums[nres] = bus.res_sum; idxs[nres] = bus.res_idx; nres++;
            end
            if (done === 1'b1) begin done_cyc = cyc; break; end
        end
        total++;
        if (nres != 2) begin bad++; $display("FAIL c2n2_count: got %0d results required 2", nres); end
        else begin
            total++;
            if (sums[0] !== 32'hFFFF_FFFC || idxs[0] !== 8'd0) begin
                bad++; $display("FAIL c2n2_n0: sum=%0d idx=%0d required -4 0", $signed(sums[0]), idxs[0]);
            end
            total++;
            if (sums[1] !== 32'd92 || idxs[1] !== 8'd1) begin
                bad++; $display("FAIL c2n2_n1: sum=%0d idx=%0d required 92 1", $signed(sums[1]), idxs[1]);
            end
        end
        total++;
        if (wt_q.size() != 4 || wt_q[0] !== 16'd0 || wt_q[1] !== 16'd1 || wt_q[2] !== 16'd2 || wt_q[3] !== 16'd3) begin
            bad++; $display("FAIL c2n2_wt_addr: got %p required 0 1 2 3", wt_q);
        end
        total++;
        if (act_q.size() != 4 || act_q[0] !== 16'd0 || act_q[1] !== 16'd1 || act_q[2] !== 16'd0 || act_q[3] !== 16'd1) begin
            bad++; $display("FAIL c2n2_act_addr: got %p required 0 1 0 1", act_q);
        end
        total++;
        if (done_cyc != 17) begin bad++; $display("FAIL c2n2_latency: done cycle %0d required 17", done_cyc); end
    endtask

    task automatic test_mem_stall();
        int nres = 0, done_cyc = -1, req_cycles = 0;
        logic [31:0] sum;
        load_basic();
        rdy_stall = 3;
        rsp_delay = 4;
        bus.res_ready = 1'b1;
        launch(8'd1, 8'd1);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.rd_valid === 1'b1) req_cycles++;
            if (bus.res_valid === 1'b1) begin nres++; sum = bus.res_sum; end
            if (done === 1'b1) begin done_cyc = cyc; break; end
        end
        rdy_stall = 0;
        rsp_delay = 1;
        total++;
        if (req_cycles != 4) begin bad++; $display("FAIL stall_req_hold: rd_valid cycles %0d required 4", req_cycles); end
        total++;
        if (nres != 1 || sum !== 32'd20) begin
            bad++; $display("FAIL stall_sum: results=%0d sum=%0d required 1 20", nres, $signed(sum));
        end
        total++;
        if (done_cyc != 12) begin bad++; $display("FAIL stall_latency: done cycle %0d required 12", done_cyc); end
    endtask

    task automatic test_backpressure();
        int r2_cyc = -1, done_cyc = -1;
        logic [31:0] r2_sum;
        logic [OUT_W-1:0] r2_idx;
        load_basic();
        bus.res_ready = 1'b0;
        launch(8'd1, 8'd2);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc >= 5 && cyc <= 9) begin
                total++;
                if (bus.res_valid !== 1'b1 || bus.res_sum !== 32'd20 || bus.res_idx !== 8'd0 ||
                    bias_idx !== 8'd0 || bus.rd_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL emit_hold: cyc=%0d valid=%b sum=%0d idx=%0d rd_valid=%b required 1 20 0 0",
                             cyc, bus.res_valid, $signed(bus.res_sum), bus.res_idx, bus.rd_valid);
                end
            end
            if (cyc == 9) bus.res_ready = 1'b1;
            if (cyc == 10) begin
                total++;
                if (bus.res_valid !== 1'b0 || bias_idx !== 8'd1) begin
                    bad++; $display("FAIL emit_release: valid=%b bias_idx=%0d required 0 1", bus.res_valid, bias_idx);
                end
            end
            if (cyc > 10 && bus.res_valid === 1'b1 && r2_cyc < 0) begin
                r2_cyc = cyc; r2_sum = bus.res_sum; r2_idx = bus.res_idx;
            end
            if (done === 1'b1) begin done_cyc = cyc; break; end
        end
        total++;
        if (r2_cyc != 14 || r2_sum !== 32'd120 || r2_idx !== 8'd1) begin
            bad++; $display("FAIL bp_second: cyc=%0d sum=%0d idx=%0d required 14 120 1", r2_cyc, $signed(r2_sum), r2_idx);
        end
        total++;
        if (done_cyc != 15) begin bad++; $display("FAIL bp_done: cycle %0d required 15", done_cyc); end
    endtask

    task automatic test_zero_and_ignore();
        int nres, done_cyc, rd_seen;
        logic [31:0] sum;
        bus.res_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            rd_seen = 0;
            done_cyc = -1;
            if (t == 0) launch(8'd3, 8'd0);
            else        launch(8'd0, 8'd2);
            for (int cyc = 1; cyc <= 5; cyc++) begin
                @(negedge clk);
                start = 1'b0;
                if (bus.rd_valid === 1'b1 || bus.res_valid === 1'b1) rd_seen++;
                if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            end
            total++;
            if (done_cyc != 1 || rd_seen != 0 || busy !== 1'b0) begin
                bad++; $display("FAIL zero_size%0d: done cycle %0d reads %0d busy=%b required 1 0 0",
                                t, done_cyc, rd_seen, busy);
            end
        end
        load_basic();
        nres = 0;
        done_cyc = -1;
        launch(8'd1, 8'd1);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc >= 2 && cyc <= 4) begin
                start = 1'b1; cfg_num_chunks = 8'd2; cfg_num_out = 8'd3;
            end else begin
                start = 1'b0;
            end
            if (bus.res_valid === 1'b1) begin nres++; sum = bus.res_sum; end
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        end
        total++;
        if (nres != 1 || sum !== 32'd20 || done_cyc != 6 || busy !== 1'b0) begin
            bad++; $display("FAIL ignore_start: results=%0d sum=%0d done cycle %0d busy=%b required 1 20 6 0",
                            nres, $signed(sum), done_cyc, busy);
        end
    endtask

    task automatic test_reset_mid();
        int leaks = 0, done_cyc = -1;
        load_basic();
        rsp_delay = 6;
        saw_rsp = 0;
        bus.res_ready = 1'b1;
        launch(8'd1, 8'd1);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++;
        if (busy !== 1'b1 || bus.rd_valid !== 1'b0) begin
            bad++; $display("FAIL mid_wait: busy=%b rd_valid=%b required 1 0", busy, bus.rd_valid);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, bus.rd_valid, bus.res_valid} !== 4'b0000 || mac_bias !== '0 ||
            bias_idx !== '0 || bus.res_sum !== '0) begin
            bad++; $display("FAIL mid_reset: ctrl=%b bias=%h idx=%0d required 0000 0 0",
                            {busy, done, bus.rd_valid, bus.res_valid}, mac_bias, bias_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0 || busy !== 1'b0 || mac_act !== '0 || bus.rd_valid !== 1'b0) leaks++;
        end
        total++;
        if (leaks != 0 || !saw_rsp) begin
            bad++; $display("FAIL late_rsp: disturbed cycles %0d late rsp seen %0d required 0 1", leaks, saw_rsp);
        end
        rsp_delay = 1;
        launch(8'd1, 8'd1);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        end
        total++;
        if (done_cyc != 6) begin bad++; $display("FAIL relaunch: done cycle %0d required 6", done_cyc); end
    endtask

`ifdef FC_SEQ_PERF_CNT_EN
    task automatic test_perf();
        load_basic();
        act_mem[0] = 32'h0;
        bus.res_ready = 1'b1;
        launch(8'd1, 8'd1);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++;
        if (perf_zero_chunks !== 16'd1 || perf_cycles !== 32'd6) begin
            bad++; $display("FAIL perf: zero_chunks=%0d cycles=%0d required 1 6", perf_zero_chunks, perf_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_two_by_two();
        test_mem_stall();
        test_backpressure();
        test_zero_and_ignore();
        test_reset_mid();
`ifdef FC_SEQ_PERF_CNT_EN
        test_perf();
`endif
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
